// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU and a DMA/loader requester.
// Optional ARB_STATS_EN macro adds stall and DMA-grant cycle counters.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       dma_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  owner_t           last_gnt;
  owner_t           last_gnt_next;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_next;
  logic             dma_locked;
  logic             dma_locked_next;
  logic             dma_hold;
  logic             cpu_gnt;

  // DMA keeps ownership only if it was granted last cycle with lock set and the cap is not reached
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    dma_hold = (last_gnt == OWNER_DMA) && dma_locked && (burst_cnt < BURST_CAP);
    if (!reset) begin
      if (cpu_req && dma_req) begin
        if (dma_hold || (last_gnt == OWNER_CPU)) begin
          dma_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign cpu_stall = cpu_req && !cpu_gnt && !reset;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  // Idle cycles keep ownership history but break the lock chain
  always_comb begin
    last_gnt_next   = last_gnt;
    burst_cnt_next  = burst_cnt;
    dma_locked_next = 1'b0;
    if (dma_gnt) begin
      last_gnt_next   = OWNER_DMA;
      dma_locked_next = dma_lock;
      if (burst_cnt < BURST_CAP) begin
        burst_cnt_next = burst_cnt + 1'b1;
      end
    end else if (cpu_gnt) begin
      last_gnt_next  = OWNER_CPU;
      burst_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= OWNER_DMA;
      burst_cnt  <= '0;
      dma_locked <= 1'b0;
    end else begin
      last_gnt   <= last_gnt_next;
      burst_cnt  <= burst_cnt_next;
      dma_locked <= dma_locked_next;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      dma_cnt   <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(cpu_stall);
      dma_cnt   <= dma_cnt + 32'(dma_gnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a rule-level reference model
// and a small behavioural data memory behind the arbiter.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 8;
  localparam int MEM_WORDS = 32;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt, dma_cnt;
  int          exp_stall_cnt;
  int          exp_dma_cnt;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_lock  (dma_lock),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rdata (dma_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef ARB_STATS_EN
    .stall_cnt (stall_cnt),
    .dma_cnt   (dma_cnt),
`endif
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem with combinational read
  logic [31:0] tb_mem [MEM_WORDS];
  assign mem_rdata = tb_mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[6:2]] <= mem_wdata;
  end

  typedef struct {
    int          cyc;
    bit          stall;
    bit          dgnt;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_cpu_rd;
    bit          chk_dma_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: who owned the port last, length of the current DMA run,
  // whether the previous cycle was a locked DMA grant, and a shadow memory
  int          m_prev_owner;
  int          m_dma_run;
  bit          m_locked_prev;
  bit          m_cpu_pend;
  bit          m_dma_pend;
  logic [31:0] shadow [MEM_WORDS];

  task automatic check_output(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rst,
                                input bit c_req, input bit c_we, input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                input bit d_req, input bit d_we, input bit d_lock, input logic [31:0] d_addr,
                                input logic [31:0] d_wdata);
    exp_t e;
    int   winner;
    reset = rst;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dma_req = d_req; dma_we = d_we; dma_lock = d_lock; dma_addr = d_addr; dma_wdata = d_wdata;

    // 0 = nobody, 1 = CPU, 2 = DMA
    winner = 0;
    if (!rst) begin
      if (c_req && d_req) begin
        if (m_prev_owner == 1 && m_locked_prev && m_dma_run < MAX_BURST) winner = 2;
        else winner = (m_prev_owner == 1) ? 1 : 2;
      end else if (c_req) winner = 1;
      else if (d_req) winner = 2;
    end

    e.cyc        = cyc;
    e.stall      = c_req && (winner != 1) && !rst;
    e.dgnt       = (winner == 2);
    e.we         = (winner == 1) ? c_we : (winner == 2) ? d_we : 1'b0;
    e.addr       = (winner == 1) ? c_addr : (winner == 2) ? d_addr : 32'h0;
    e.wdata      = (winner == 1) ? c_wdata : (winner == 2) ? d_wdata : 32'h0;
    e.chk_cpu_rd = (winner == 1) && !c_we;
    e.chk_dma_rd = (winner == 2) && !d_we;
    e.rdata      = shadow[e.addr[6:2]];
    sb.push_back(e);

    if (rst) begin
      m_prev_owner  = 1;
      m_dma_run     = 0;
      m_locked_prev = 0;
`ifdef ARB_STATS_EN
      exp_stall_cnt = 0;
      exp_dma_cnt   = 0;
`endif
    end else begin
`ifdef ARB_STATS_EN
      exp_stall_cnt += int'(e.stall);
      exp_dma_cnt   += int'(e.dgnt);
`endif
      m_locked_prev = 0;
      if (winner == 2) begin
        m_prev_owner  = 1;
        m_locked_prev = d_lock;
        if (m_dma_run < MAX_BURST) m_dma_run++;
      end else if (winner == 1) begin
        m_prev_owner = 0;
        m_dma_run    = 0;
      end
      if (winner != 0 && e.we) shadow[e.addr[6:2]] = e.wdata;
    end
    m_cpu_pend = c_req && (winner != 1) && !rst;
    m_dma_pend = d_req && (winner != 2) && !rst;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic both_req(input int n, input bit lock);
    for (int i = 0; i < n; i++)
      apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, lock, 32'h40 + 32'(4 * i), 32'h0);
  endtask

  // Monitor: pops one expectation per cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output("cpu_stall", e.cyc, {31'b0, cpu_stall}, {31'b0, e.stall});
      check_output("dma_gnt", e.cyc, {31'b0, dma_gnt}, {31'b0, e.dgnt});
      check_output("mem_we", e.cyc, {31'b0, mem_we}, {31'b0, e.we});
      check_output("mem_addr", e.cyc, mem_addr, e.addr);
      check_output("mem_wdata", e.cyc, mem_wdata, e.wdata);
      if (e.chk_cpu_rd) check_output("cpu_rdata", e.cyc, cpu_rdata, e.rdata);
      if (e.chk_dma_rd) check_output("dma_rdata", e.cyc, dma_rdata, e.rdata);
    end
  end

  initial begin
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    bit          c_req, c_we, d_req, d_we, d_lock, rst;
    int          wait_cycles;

    for (int i = 0; i < MEM_WORDS; i++) begin
      tb_mem[i] = $urandom;
      shadow[i] = tb_mem[i];
    end
    m_prev_owner = 1; m_dma_run = 0; m_locked_prev = 0; m_cpu_pend = 0; m_dma_pend = 0;
`ifdef ARB_STATS_EN
    exp_stall_cnt = 0; exp_dma_cnt = 0;
`endif
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    @(posedge clk);
    #1;

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 32'h10, 32'h1, 1, 1, 1, 32'h14, 32'h2);

    // CPU-only store then load of the same word
    apply_stimulus(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0);

    // First contention after reset, then round-robin alternation
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    both_req(6, 0);

    // Burst cap: CPU, then 8 locked DMA grants, then CPU, then DMA again
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    both_req(9, 1);
`ifdef ARB_STATS_EN
    check_output("dma_cnt_burst", cyc, dma_cnt, 32'd8);
    check_output("stall_cnt_burst", cyc, stall_cnt, 32'd8);
`endif
    both_req(3, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_STATS_EN
    check_output("dma_cnt_reset", cyc, dma_cnt, 32'd0);
    check_output("stall_cnt_reset", cyc, stall_cnt, 32'd0);
`endif

    // Reset during the third locked DMA grant, then contention again
    both_req(3, 1);
    apply_stimulus(1, 1, 0, 32'h20, 32'h0, 1, 0, 1, 32'h4C, 32'h0);
    both_req(3, 1);

    // Randomized traffic; stalled requesters hold their request
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_cpu_pend) begin
        c_req   = ($urandom_range(0, 9) < 6);
        c_we    = $urandom_range(0, 1) == 1;
        c_addr  = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
        c_wdata = $urandom;
      end
      if (!m_dma_pend) begin
        d_req   = ($urandom_range(0, 9) < 6);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
        d_wdata = $urandom;
      end
      d_lock = ($urandom_range(0, 9) < 7);
      rst    = ($urandom_range(0, 299) == 0);
      apply_stimulus(rst, c_req, c_we, c_addr, c_wdata, d_req, d_we, d_lock, d_addr, d_wdata);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef ARB_STATS_EN
    check_output("stall_cnt_total", cyc, stall_cnt, 32'(exp_stall_cnt));
    check_output("dma_cnt_total", cyc, dma_cnt, 32'(exp_dma_cnt));
`endif

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
